sync_fifo_gen: RTL
==================

SYNC_FIFO_GEN -- requirements
Module: sync_fifo_gen

Interface
REQ-001 The module SHALL have parameter FIFO_width, default 16, meaning data path and word width in bits.
REQ-002 The module SHALL have parameter FIFO_depth, default 8, meaning number of words; legal values are powers of two, 2 to 1024.
REQ-003 The module SHALL have parameter AF_level, default 6, meaning almost_full asserts when count >= AF_level; legal range 1..FIFO_depth.
REQ-004 The module SHALL have parameter AE_level, default 2, meaning almost_empty asserts when count <= AE_level; legal range 0..FIFO_depth-1.
REQ-005 The module SHALL derive the pointer width internally as ptr_width = $clog2(FIFO_depth); there is no ptr_width parameter.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 The module SHALL have port clear, input, 1 bit: synchronous flush.
REQ-009 The module SHALL have port Data_in, input, FIFO_width bits: write data.
REQ-010 The module SHALL have port wr_enable, input, 1 bit: write request.
REQ-011 The module SHALL have port rd_enable, input, 1 bit: read request.
REQ-012 The module SHALL have port Data_out, output, FIFO_width bits: registered read data.
REQ-013 The module SHALL have port rd_valid, output, 1 bit: Data_out updated this cycle.
REQ-014 The module SHALL have ports empty and full, outputs, 1 bit each: occupancy flags.
REQ-015 The module SHALL have ports almost_empty and almost_full, outputs, 1 bit each: threshold flags.
REQ-016 The module SHALL have port count, output, ptr_width+1 bits: words stored, 0..FIFO_depth.

Function
REQ-017 empty SHALL be (count==0) and full SHALL be (count==FIFO_depth); both combinational from registered count.
REQ-018 A write SHALL be accepted when wr_enable && !full; Data_in is stored at write_ptr and write_ptr increments modulo FIFO_depth.
REQ-019 A read SHALL be accepted when rd_enable && !empty; Data_out <= mem[read_ptr] on that edge (1-cycle latency), read_ptr increments modulo FIFO_depth, and rd_valid is 1 for the following cycle.
REQ-020 Accepted read and write in the same cycle SHALL both execute; count is unchanged.
REQ-021 When full, a simultaneous read and write SHALL accept the read only; when empty, a simultaneous read and write SHALL accept the write only (flags are sampled before the edge).
REQ-022 count SHALL increment on write-only, decrement on read-only, and hold otherwise; it never exceeds FIFO_depth or goes below 0.
REQ-023 Rejected requests (write when full, read when empty) SHALL leave memory, pointers, count and Data_out unchanged.
REQ-024 Data_out SHALL hold its last value when no read is accepted; rd_valid SHALL be 0 in every cycle not following an accepted read.
REQ-025 clear SHALL take priority over reads and writes: pointers and count go to 0, rd_valid goes to 0, Data_out holds, and memory contents are don't-care.
REQ-026 almost_full and almost_empty SHALL be combinational compares of count against AF_level and AE_level.

Reset
REQ-027 rst high SHALL immediately force read_ptr=0, write_ptr=0, count=0, Data_out=0 and rd_valid=0, giving empty=1, full=0, almost_empty=1 and almost_full=0 (for AF_level>0); memory is not reset.
REQ-028 Deasserting rst mid-operation SHALL leave the FIFO empty, with the first accepted write after release stored at address 0.

Configuration
REQ-029 With FIFO_ERR_FLAGS_EN defined, the module SHALL add outputs overflow and underflow (1 bit each, sticky): overflow sets on wr_enable && full && !clear, underflow sets on rd_enable && empty && !clear, and both are cleared by rst or clear.
REQ-030 Without FIFO_ERR_FLAGS_EN, the overflow and underflow ports and their logic SHALL be absent; all other behaviour is identical.

Verification (FIFO_width=16, FIFO_depth=8, AF_level=6, AE_level=2)
REQ-031 Write 0x0001..0x0008 on consecutive cycles, then 9th write 0xFFFF -> full=1, count=8, 9th write dropped (overflow=1 if enabled); reading 8 words returns 0x0001..0x0008, each with rd_valid.
REQ-032 Fill to count=4, then hold rd_enable=wr_enable=1 for 20 cycles -> count stays 4, pointers wrap, output order matches input order.
REQ-033 At full, assert rd_enable and wr_enable together -> read accepted, write dropped, count=7; at empty, assert both -> write accepted, count=1, rd_valid=0.
REQ-034 Step count 0->8->0 -> almost_empty=1 for count<=2, almost_full=1 for count>=6, exact transitions at 2->3 and 5->6.
REQ-035 At count=5, assert clear together with wr_enable -> next cycle count=0, empty=1, write discarded, Data_out unchanged.
REQ-036 Assert rst asynchronously mid-clock while count=3 -> outputs reset before the next edge; the write after release reads back first.

Source files
------------

// File: rtl/sync_fifo_gen.sv
//==============================================================================
// Module   : sync_fifo_gen
// Summary  : Single-clock FIFO. Read data is registered, occupancy is counted,
//            and the full/empty/almost flags are derived from that count.
// Options  : define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_fifo_gen #(
  parameter int FIFO_width = 16,
  parameter int FIFO_depth = 8,
  parameter int AF_level   = 6,
  parameter int AE_level   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic [FIFO_width-1:0]         Data_in,
  input  logic                          wr_enable,
  input  logic                          rd_enable,
  output logic [FIFO_width-1:0]         Data_out,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                          overflow,
  output logic                          underflow,
`endif
  output logic [$clog2(FIFO_depth):0]   count
);

  localparam int ptr_width = $clog2(FIFO_depth);

  // Thresholds and constants pre-sized to the count/pointer widths.
  localparam logic [ptr_width:0]   depth_cnt = (ptr_width+1)'(FIFO_depth);
  localparam logic [ptr_width:0]   af_cnt    = (ptr_width+1)'(AF_level);
  localparam logic [ptr_width:0]   ae_cnt    = (ptr_width+1)'(AE_level);
  localparam logic [ptr_width:0]   cnt_one   = (ptr_width+1)'(1);
  localparam logic [ptr_width-1:0] ptr_one   = ptr_width'(1);

  logic [FIFO_width-1:0] mem [FIFO_depth];
  logic [ptr_width-1:0]  write_ptr;
  logic [ptr_width-1:0]  read_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come straight from the registered count.
  assign empty        = (count == '0);
  assign full         = (count == depth_cnt);
  assign almost_full  = (count >= af_cnt);
  assign almost_empty = (count <= ae_cnt);

  // Requests are qualified by the pre-edge flags; a flush overrides both.
  assign wr_acc = wr_enable && !full  && !clear;
  assign rd_acc = rd_enable && !empty && !clear;

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[write_ptr] <= Data_in;
    end
  end

  // Pointers, occupancy count, registered read data and its valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
      Data_out  <= '0;
      rd_valid  <= 1'b0;
    end else if (clear) begin
      // Flush: Data_out deliberately keeps its last value.
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        write_ptr <= write_ptr + ptr_one;
      end
      if (rd_acc) begin
        Data_out <= mem[read_ptr];
        read_ptr <= read_ptr + ptr_one;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; a flush cycle neither sets them nor keeps them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_enable && full) begin
        overflow <= 1'b1;
      end
      if (rd_enable && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
